// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer
// Instruction fetch front-end that sits between the instruction memory bus and
// the IF/ID register. It issues word-aligned requests, counts in-flight
// transactions and buffers returned words in a DEPTH-entry FIFO. On a
// branch/jump redirect it flushes the FIFO and drops responses that are still
// in flight, then restarts fetching at the target.
//
// Optional feature macro: FETCH_ERR_CHECK_EN
//   defined   : instr_err_i is stored per entry and shown on fetch_err_o. After an
//               erroring response, no new request is issued until a redirect.
//   undefined : instr_err_i is ignored and fetch_err_o is tied to 0.
//
// Handshakes:
//   bus    : instr_req_o stays high with a stable instr_addr_o until instr_gnt_i.
//            Responses (instr_rvalid_i) return in request order.
//   decoder: a word transfers in a cycle where fetch_valid_o and fetch_ready_i
//            are both high. The head stays stable while fetch_ready_i is low.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   boot_addr_i                       first fetch address after reset
//   fetch_en_i                        allows new requests
//   redirect_i, redirect_addr_i       taken branch/jump and its target
//   instr_req_o/gnt_i/addr_o          request channel
//   instr_rvalid_i/rdata_i/err_i      response channel
//   fetch_valid_o/ready_i             head handshake toward IF/ID
//   fetch_rdata_o/addr_o/err_o        head word, its PC and its error flag
//   busy_o                            at least one transaction outstanding
module instr_prefetch_buffer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] boot_addr_i,
    input  logic        fetch_en_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        fetch_valid_o,
    input  logic        fetch_ready_i,
    output logic [31:0] fetch_rdata_o,
    output logic [31:0] fetch_addr_o,
    output logic        fetch_err_o,
    output logic        busy_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_GNT = 1'b1
    } state_t;

    state_t        state;
    logic [31:0]   fetch_addr;
    logic          boot_pending;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] out_next;

    // Response FIFO
    logic [31:0]   fifo_rdata [DEPTH];
    logic [31:0]   fifo_addr  [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] fifo_count;

    // Addresses of issued requests, one slot per outstanding transaction
    logic [31:0]   aq_addr [DEPTH];
    logic [PW-1:0] aq_rd;
    logic [PW-1:0] aq_wr;

    logic          pop;
    logic          push;
    logic          grant;
    logic          can_issue;
    logic          err_block;
    logic [CW:0]   occupancy;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign fetch_valid_o = (fifo_count != '0);
    assign pop           = fetch_valid_o & fetch_ready_i;

    // A head that is popped this cycle frees its slot, so it is not counted.
    // This keeps one word per cycle flowing with DEPTH=2. The total of
    // buffered and in-flight words still never exceeds DEPTH.
    assign occupancy = {1'b0, fifo_count} + {1'b0, outstanding} - {{CW{1'b0}}, pop};

    assign can_issue = fetch_en_i & ~boot_pending & ~redirect_i & ~err_block &
                       (occupancy < DEPTH_OCC);

    // A request in WAIT_GNT stays asserted until it is granted. It is only
    // withdrawn after a redirect moves the FSM back to IDLE.
    assign instr_req_o  = (state == WAIT_GNT) | can_issue;
    assign grant        = instr_req_o & instr_gnt_i;
    assign instr_addr_o = fetch_addr;
    assign busy_o       = (outstanding != '0);

    // Responses that belong to a flushed stream are dropped.
    // This covers responses counted in discard and any response that
    // arrives in the same cycle as the redirect.
    assign push = instr_rvalid_i & ~redirect_i & (discard == '0);

    always_comb begin
        out_next = outstanding;
        if (grant && !instr_rvalid_i) begin
            out_next = outstanding + 1'b1;
        end else if (!grant && instr_rvalid_i) begin
            out_next = outstanding - 1'b1;
        end
    end

    // Request FSM, fetch address and transaction counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            fetch_addr   <= '0;
            boot_pending <= 1'b1;
            outstanding  <= '0;
            discard      <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect_i) begin
                // A grant in this same cycle is already included in out_next.
                // It is discarded together with the older in-flight requests.
                state        <= IDLE;
                fetch_addr   <= {redirect_addr_i[31:2], 2'b00};
                boot_pending <= 1'b0;
                discard      <= out_next;
            end else begin
                if (boot_pending) begin
                    fetch_addr   <= {boot_addr_i[31:2], 2'b00};
                    boot_pending <= 1'b0;
                end else if (grant) begin
                    fetch_addr <= fetch_addr + 32'd4;
                end
                case (state)
                    IDLE:     if (instr_req_o && !instr_gnt_i) state <= WAIT_GNT;
                    WAIT_GNT: if (instr_gnt_i) state <= IDLE;
                    default:  state <= IDLE;
                endcase
                if (instr_rvalid_i && discard != '0) begin
                    discard <= discard - 1'b1;
                end
            end
        end
    end

    // Request address queue and response FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                aq_addr[i]    <= '0;
                fifo_rdata[i] <= '0;
                fifo_addr[i]  <= '0;
            end
            aq_rd      <= '0;
            aq_wr      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            // The address queue also tracks discarded transactions, so it is
            // never flushed. Every response pops its own entry.
            if (grant) begin
                aq_addr[aq_wr] <= fetch_addr;
                aq_wr          <= ptr_inc(aq_wr);
            end
            if (instr_rvalid_i) begin
                aq_rd <= ptr_inc(aq_rd);
            end

            if (redirect_i) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (push) begin
                    fifo_rdata[wr_ptr] <= instr_rdata_i;
                    fifo_addr[wr_ptr]  <= aq_addr[aq_rd];
                    wr_ptr             <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                if (push && !pop) begin
                    fifo_count <= fifo_count + 1'b1;
                end else if (!push && pop) begin
                    fifo_count <= fifo_count - 1'b1;
                end
            end
        end
    end

    assign fetch_rdata_o = fifo_rdata[rd_ptr];
    assign fetch_addr_o  = fifo_addr[rd_ptr];

`ifdef FETCH_ERR_CHECK_EN
    logic fifo_err [DEPTH];
    logic err_lock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_err[i] <= 1'b0;
            end
            err_lock <= 1'b0;
        end else begin
            if (push) begin
                fifo_err[wr_ptr] <= instr_err_i;
            end
            // Fetching past a faulting word is pointless. Stop until the
            // core redirects, usually to an exception handler.
            if (redirect_i) begin
                err_lock <= 1'b0;
            end else if (push && instr_err_i) begin
                err_lock <= 1'b1;
            end
        end
    end

    assign err_block   = err_lock;
    assign fetch_err_o = fifo_err[rd_ptr];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{boot_addr_i[1:0], redirect_addr_i[1:0]};
`else
    assign err_block   = 1'b0;
    assign fetch_err_o = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{boot_addr_i[1:0], redirect_addr_i[1:0], instr_err_i};
`endif

`ifndef SYNTHESIS
    a_gnt_needs_req : assert property (@(posedge clk) disable iff (!rst_n)
        instr_gnt_i |-> instr_req_o);
    a_rvalid_needs_outstanding : assert property (@(posedge clk) disable iff (!rst_n)
        instr_rvalid_i |-> (outstanding != '0));
    a_outstanding_bound : assert property (@(posedge clk) disable iff (!rst_n)
        {1'b0, outstanding} <= DEPTH_OCC);
`endif

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer with DEPTH=2. A cycle table covers
// boot and streaming. Hand-written sequences cover continuous flow,
// back-pressure, redirect flush, a grant held back during WAIT_GNT, and
// address wrap.
module tb_instr_prefetch_buffer;

    localparam int DEPTH = 2;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] boot_addr;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        instr_req;
    logic        instr_gnt;
    logic [31:0] instr_addr;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_rdata;
    logic [31:0] fetch_addr;
    logic        fetch_err;
    logic        busy;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_prefetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .boot_addr_i     (boot_addr),
        .fetch_en_i      (fetch_en),
        .redirect_i      (redirect),
        .redirect_addr_i (redirect_addr),
        .instr_req_o     (instr_req),
        .instr_gnt_i     (instr_gnt),
        .instr_addr_o    (instr_addr),
        .instr_rvalid_i  (instr_rvalid),
        .instr_rdata_i   (instr_rdata),
        .instr_err_i     (instr_err),
        .fetch_valid_o   (fetch_valid),
        .fetch_ready_i   (fetch_ready),
        .fetch_rdata_o   (fetch_rdata),
        .fetch_addr_o    (fetch_addr),
        .fetch_err_o     (fetch_err),
        .busy_o          (busy)
    );

    typedef struct {
        logic        fe;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_fv;
        logic [31:0] e_frd;
        logic [31:0] e_fad;
        logic        e_busy;
    } vec_t;

    vec_t tbl[8];

    // Memory contents the bench answers with
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic vec_t mk(input logic fe, gnt, rv, input logic [31:0] rdata,
                                input logic rdy, req, input logic [31:0] addr,
                                input logic fv, input logic [31:0] frd, fad,
                                input logic bsy);
        vec_t v;
        v.fe = fe; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy;
        v.e_req = req; v.e_addr = addr; v.e_fv = fv; v.e_frd = frd; v.e_fad = fad;
        v.e_busy = bsy;
        return v;
    endfunction

    // ---------------- checkers ----------------
    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                              input logic fv, input logic [31:0] frd, input logic [31:0] fad,
                              input logic ferr, input logic bsy);
        chk1({tag, ".req"}, instr_req, req);
        chk32({tag, ".addr"}, instr_addr, addr);
        chk1({tag, ".fvalid"}, fetch_valid, fv);
        chk1({tag, ".busy"}, busy, bsy);
        if (fv) begin
            chk32({tag, ".frdata"}, fetch_rdata, frd);
            chk32({tag, ".faddr"}, fetch_addr, fad);
            chk1({tag, ".ferr"}, fetch_err, ferr);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive at posedge+1, check at the negedge, then advance to the next posedge+1.
    task automatic run(input string tag, input logic fe, rd, input logic [31:0] ra,
                       input logic gnt, rv, input logic [31:0] rdat, input logic err, rdy,
                       input logic req, input logic [31:0] addr, input logic fv,
                       input logic [31:0] frd, fad, input logic ferr, bsy);
        fetch_en      = fe;
        redirect      = rd;
        redirect_addr = ra;
        instr_gnt     = gnt;
        instr_rvalid  = rv;
        instr_rdata   = rdat;
        instr_err     = err;
        fetch_ready   = rdy;
        @(negedge clk);
        expect_out(tag, req, addr, fv, frd, fad, ferr, bsy);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] boot);
        rst_n         = 1'b0;
        boot_addr     = boot;
        fetch_en      = 1'b0;
        redirect      = 1'b0;
        redirect_addr = '0;
        instr_gnt     = 1'b0;
        instr_rvalid  = 1'b0;
        instr_rdata   = '0;
        instr_err     = 1'b0;
        fetch_ready   = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk1("rst.req", instr_req, 1'b0);
        chk32("rst.addr", instr_addr, 32'h0);
        chk1("rst.fvalid", fetch_valid, 1'b0);
        chk32("rst.frdata", fetch_rdata, 32'h0);
        chk32("rst.faddr", fetch_addr, 32'h0);
        chk1("rst.ferr", fetch_err, 1'b0);
        chk1("rst.busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;

        // Boot at 0x82 -> fetches from 0x80. Zero-wait bus, then drain.
        tbl[0] = mk(1, 0, 0, 0,                    1, 0, 32'h00, 0, 0,                    0,     0);
        tbl[1] = mk(1, 1, 0, 0,                    1, 1, 32'h80, 0, 0,                    0,     0);
        tbl[2] = mk(1, 1, 1, mem_word(32'h80),     1, 1, 32'h84, 0, 0,                    0,     1);
        tbl[3] = mk(1, 1, 1, mem_word(32'h84),     1, 1, 32'h88, 1, mem_word(32'h80), 32'h80, 1);
        tbl[4] = mk(1, 1, 1, mem_word(32'h88),     1, 1, 32'h8C, 1, mem_word(32'h84), 32'h84, 1);
        tbl[5] = mk(0, 0, 1, mem_word(32'h8C),     1, 0, 32'h90, 1, mem_word(32'h88), 32'h88, 1);
        tbl[6] = mk(0, 0, 0, 0,                    1, 0, 32'h90, 1, mem_word(32'h8C), 32'h8C, 0);
        tbl[7] = mk(0, 0, 0, 0,                    1, 0, 32'h90, 0, 0,                    0,     0);

        do_reset(32'h0000_0082);
        for (int i = 0; i < 8; i++) begin
            run($sformatf("tbl%0d", i), tbl[i].fe, 1'b0, 32'h0, tbl[i].gnt, tbl[i].rv,
                tbl[i].rdata, 1'b0, tbl[i].rdy, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_fv,
                tbl[i].e_frd, tbl[i].e_fad, 1'b0, tbl[i].e_busy);
        end

        // Continuous streaming: one word per cycle, PC +4 each cycle.
        // The run ends mid-stream, and the next reset clears it.
        do_reset(32'h0000_0100);
        run("strm0", 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            a = 32'h100 + 32'(4 * (k - 3));
            run($sformatf("strm%0d", k), 1, 0, 0, 1, (k >= 2),
                (k >= 2) ? mem_word(32'h100 + 32'(4 * (k - 2))) : 32'h0, 0, 1,
                1, 32'h100 + 32'(4 * (k - 1)), (k >= 3), mem_word(a), a, 0, (k >= 2));
        end

        // Back-pressure: ready low for 11 cycles -> only two grants, head held.
        do_reset(32'h0000_0200);
        run("bp0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0);
        run("bp1", 1, 0, 0, 1, 0, 0, 0, 0, 1, 32'h200, 0, 0, 0, 0, 0);
        run("bp2", 1, 0, 0, 1, 1, mem_word(32'h200), 0, 0, 1, 32'h204, 0, 0, 0, 0, 1);
        run("bp3", 1, 0, 0, 0, 1, mem_word(32'h204), 0, 0, 0, 32'h208,
            1, mem_word(32'h200), 32'h200, 0, 1);
        for (int k = 4; k <= 10; k++) begin
            run($sformatf("bp%0d", k), 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h208,
                1, mem_word(32'h200), 32'h200, 0, 0);
        end
        run("bp11", 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h208, 1, mem_word(32'h200), 32'h200, 0, 0);
        run("bp12", 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h208, 1, mem_word(32'h204), 32'h204, 0, 0);
        run("bp13", 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h208, 0, 0, 0, 0, 0);

        // Redirect with two requests outstanding: both late responses are dropped.
        do_reset(32'h0000_0300);
        run("rd0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0);
        run("rd1", 1, 0, 0, 1, 0, 0, 0, 0, 1, 32'h300, 0, 0, 0, 0, 0);
        run("rd2", 1, 0, 0, 1, 0, 0, 0, 0, 1, 32'h304, 0, 0, 0, 0, 1);
        run("rd3", 1, 1, 32'h0000_0202, 0, 0, 0, 0, 0, 0, 32'h308, 0, 0, 0, 0, 1);
        run("rd4", 0, 0, 0, 0, 1, 32'hDEAD_0001, 0, 1, 0, 32'h200, 0, 0, 0, 0, 1);
        run("rd5", 0, 0, 0, 0, 1, 32'hDEAD_0002, 0, 1, 0, 32'h200, 0, 0, 0, 0, 1);
        run("rd6", 1, 0, 0, 1, 0, 0, 0, 1, 1, 32'h200, 0, 0, 0, 0, 0);
        run("rd7", 0, 0, 0, 0, 1, mem_word(32'h200), 0, 1, 0, 32'h204, 0, 0, 0, 0, 1);
        run("rd8", 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h204, 1, mem_word(32'h200), 32'h200, 0, 0);

        // Grant held back 3 cycles -> address stable. A redirect withdraws the request.
        // A later redirect flushes a buffered head.
        do_reset(32'h0000_0400);
        run("wg0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0);
        run("wg1", 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h400, 0, 0, 0, 0, 0);
        run("wg2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h400, 0, 0, 0, 0, 0);
        run("wg3", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h400, 0, 0, 0, 0, 0);
        run("wg4", 0, 1, 32'h500, 0, 0, 0, 0, 0, 1, 32'h400, 0, 0, 0, 0, 0);
        run("wg5", 1, 0, 0, 1, 0, 0, 0, 0, 1, 32'h500, 0, 0, 0, 0, 0);
        run("wg6", 0, 0, 0, 0, 1, mem_word(32'h500), 0, 0, 0, 32'h504, 0, 0, 0, 0, 1);
        run("wg7", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h504, 1, mem_word(32'h500), 32'h500, 0, 0);
        run("wg8", 0, 1, 32'h700, 0, 0, 0, 0, 0, 0, 32'h504, 1, mem_word(32'h500), 32'h500, 0, 0);
        run("wg9", 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h700, 0, 0, 0, 0, 0);

        // A redirect in the boot cycle wins over boot_addr. The fetch address wraps.
        do_reset(32'h0000_0082);
        run("wr0", 1, 1, 32'hFFFF_FFFE, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0);
        run("wr1", 1, 0, 0, 1, 0, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        run("wr2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 1);
        run("wr3", 0, 0, 0, 0, 1, 32'h1234_5678, 0, 1, 0, 32'h0, 0, 0, 0, 0, 1);
        run("wr4", 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 1, 32'h1234_5678, 32'hFFFF_FFFC, 0, 0);

`ifdef FETCH_ERR_CHECK_EN
        // An erroring word at 0x104 blocks new requests until a redirect.
        do_reset(32'h0000_0100);
        run("er0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0);
        run("er1", 1, 0, 0, 1, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0);
        run("er2", 1, 0, 0, 1, 1, mem_word(32'h100), 0, 0, 1, 32'h104, 0, 0, 0, 0, 1);
        run("er3", 1, 0, 0, 0, 1, mem_word(32'h104), 1, 0, 0, 32'h108,
            1, mem_word(32'h100), 32'h100, 0, 1);
        run("er4", 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h108, 1, mem_word(32'h100), 32'h100, 0, 0);
        run("er5", 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h108, 1, mem_word(32'h104), 32'h104, 1, 0);
        run("er6", 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h108, 0, 0, 0, 0, 0);
        run("er7", 1, 1, 32'h100, 0, 0, 0, 0, 1, 0, 32'h108, 0, 0, 0, 0, 0);
        run("er8", 1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h100, 0, 0, 0, 0, 0);
`endif

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
